// File: rtl/regfile_sb_pkg.sv
// Shared constants for the NPC integer register file and its scoreboard.
package regfile_sb_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned NR_REGS    = 2**REG_ADDR_W;
   localparam int unsigned REG_ZERO   = 0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_rd_port.sv
// One combinational read port: x0 forcing, optional write bypass, and operand-busy flag.
module regfile_rd_port
   import regfile_sb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
   parameter int unsigned DATA_WIDTH = XLEN,
   parameter int unsigned BYPASS     = 1
) (
   input  logic [ADDR_WIDTH-1:0]    raddr_i,
   input  logic [DATA_WIDTH-1:0]    rf_i [2**ADDR_WIDTH],
   input  logic                     wen_i,
   input  logic [ADDR_WIDTH-1:0]    waddr_i,
   input  logic [DATA_WIDTH-1:0]    wdata_i,
   input  logic [2**ADDR_WIDTH-1:0] busy_i,
   output logic [DATA_WIDTH-1:0]    rdata_o,
   output logic                     rs_busy_o
);

   logic fwd;

   // A same-cycle writeback both supplies the data and retires the pending producer.
   assign fwd = (BYPASS != 0) && wen_i && (waddr_i == raddr_i);

   always_comb begin
      rdata_o   = '0;
      rs_busy_o = 1'b0;
      if (raddr_i != ADDR_WIDTH'(REG_ZERO)) begin
         rdata_o   = fwd ? wdata_i : rf_i[raddr_i];
         rs_busy_o = busy_i[raddr_i] & ~fwd;
      end
   end

endmodule : regfile_rd_port

// File: rtl/regfile_sb.sv
// Integer register file with NR_READ read ports, one write port and a per-register busy scoreboard.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
   parameter int unsigned DATA_WIDTH = XLEN,
   parameter int unsigned NR_READ    = 2,
   parameter int unsigned BYPASS     = 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             wen,
   input  logic [ADDR_WIDTH-1:0]            waddr,
   input  logic [DATA_WIDTH-1:0]            wdata,
   input  logic [NR_READ*ADDR_WIDTH-1:0]    raddr,
   output logic [NR_READ*DATA_WIDTH-1:0]    rdata,
   input  logic                             issue_en,
   input  logic [ADDR_WIDTH-1:0]            issue_rd,
   output logic [NR_READ-1:0]               rs_busy,
   output logic [2**ADDR_WIDTH-1:0]         busy_vec,
   output logic                             err
);

   localparam int unsigned NREGS = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] rf_q [NREGS];
   logic [NREGS-1:0]      busy_q, busy_d;
   logic                  err_q, err_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NREGS; k++) begin
            rf_q[k] <= '0;
         end
      end else if (wen && (waddr != ADDR_WIDTH'(REG_ZERO))) begin
         rf_q[waddr] <= wdata;
      end
   end

   // Issue takes priority over writeback so a re-issued register stays pending.
   always_comb begin
      busy_d = busy_q;
      for (int unsigned k = 1; k < NREGS; k++) begin
         if (issue_en && (issue_rd == ADDR_WIDTH'(k))) begin
            busy_d[k] = 1'b1;
         end else if (wen && (waddr == ADDR_WIDTH'(k))) begin
            busy_d[k] = 1'b0;
         end
      end
      busy_d[0] = 1'b0;

      err_d = err_q;
      if (issue_en && (issue_rd != ADDR_WIDTH'(REG_ZERO)) && busy_q[issue_rd] &&
          !(wen && (waddr == issue_rd))) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_vec = busy_q;
   assign err      = err_q;

   for (genvar g = 0; g < NR_READ; g++) begin : g_rd
      regfile_rd_port #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .BYPASS     (BYPASS)
      ) u_rd (
         .raddr_i   (raddr[g*ADDR_WIDTH +: ADDR_WIDTH]),
         .rf_i      (rf_q),
         .wen_i     (wen),
         .waddr_i   (waddr),
         .wdata_i   (wdata),
         .busy_i    (busy_q),
         .rdata_o   (rdata[g*DATA_WIDTH +: DATA_WIDTH]),
         .rs_busy_o (rs_busy[g])
      );
   end

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb; a bypass and a non-bypass instance share one stimulus stream.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [9:0]  raddr;
   logic        issue_en;
   logic [4:0]  issue_rd;

   logic [63:0] rdata_b, rdata_n;
   logic [1:0]  rs_busy_b, rs_busy_n;
   logic [31:0] busy_vec_b, busy_vec_n;
   logic        err_b, err_n;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_b), .issue_en(issue_en), .issue_rd(issue_rd),
      .rs_busy(rs_busy_b), .busy_vec(busy_vec_b), .err(err_b)
   );

   regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NR_READ(2), .BYPASS(0)) u_nob (
      .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata_n), .issue_en(issue_en), .issue_rd(issue_rd),
      .rs_busy(rs_busy_n), .busy_vec(busy_vec_n), .err(err_n)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge; the following rising edge commits them.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      wen = 1'b0; waddr = '0; wdata = '0; issue_en = 1'b0; issue_rd = '0;
   endtask

   initial begin
      rst_n = 1'b0; raddr = '0;
      idle();
      @(negedge clk);
      tick();

      // 1: reset state
      rst_n = 1'b1; raddr = {5'd5, 5'd3};
      #1;
      chk("rst_rdata",    rdata_b,    64'h0);
      chk("rst_rs_busy",  rs_busy_b,  2'b00);
      chk("rst_busy_vec", busy_vec_b, 32'h0);
      chk("rst_err",      err_b,      1'b0);

      // 2: write x3, write x0
      @(negedge clk);
      wen = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd3};
      #1;
      chk("wr3_byp_same", rdata_b[31:0], 32'hDEADBEEF);
      chk("wr3_nob_same", rdata_n[31:0], 32'h0);
      tick();
      idle();
      #1;
      chk("rd3_byp", rdata_b[31:0], 32'hDEADBEEF);
      chk("rd3_nob", rdata_n[31:0], 32'hDEADBEEF);
      wen = 1'b1; waddr = 5'd0; wdata = 32'h1234; raddr = {5'd0, 5'd0};
      #1;
      chk("wr0_byp_same", rdata_b, 64'h0);
      tick();
      idle();
      #1;
      chk("rd0_byp", rdata_b, 64'h0);
      chk("rd0_nob", rdata_n, 64'h0);

      // 3: bypass vs stored value on x7
      wen = 1'b1; waddr = 5'd7; wdata = 32'h11111111;
      tick();
      wdata = 32'hA5A5A5A5; raddr = {5'd7, 5'd7};
      #1;
      chk("byp7_p0",  rdata_b[31:0],  32'hA5A5A5A5);
      chk("byp7_p1",  rdata_b[63:32], 32'hA5A5A5A5);
      chk("nob7_old", rdata_n[31:0],  32'h11111111);
      tick();
      idle();
      #1;
      chk("nob7_new", rdata_n[31:0], 32'hA5A5A5A5);

      // 4: issue x9, then write it back
      issue_en = 1'b1; issue_rd = 5'd9; raddr = {5'd9, 5'd0};
      tick();
      idle();
      #1;
      chk("busy9_byp",  rs_busy_b,     2'b10);
      chk("busy9_nob",  rs_busy_n,     2'b10);
      chk("busyvec9",   busy_vec_b,    32'h0000_0200);
      wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
      #1;
      chk("wb9_byp_rsbusy", rs_busy_b, 2'b00);
      chk("wb9_nob_rsbusy", rs_busy_n, 2'b10);
      chk("wb9_byp_data",   rdata_b[63:32], 32'h99);
      tick();
      idle();
      #1;
      chk("busyvec9_clr", busy_vec_b, 32'h0);
      chk("rs_busy9_clr", rs_busy_n,  2'b00);

      // issue of x0 is a no-op
      issue_en = 1'b1; issue_rd = 5'd0;
      tick();
      idle();
      #1;
      chk("issue0_busy", busy_vec_b, 32'h0);

      // 5: set wins over writeback, then double issue raises err
      issue_en = 1'b1; issue_rd = 5'd4;
      tick();
      idle();
      #1;
      chk("busy4_set", busy_vec_b, 32'h0000_0010);
      issue_en = 1'b1; issue_rd = 5'd4; wen = 1'b1; waddr = 5'd4; wdata = 32'h44;
      tick();
      idle();
      #1;
      chk("busy4_setwins", busy_vec_b, 32'h0000_0010);
      chk("err_after_wb",  err_b,      1'b0);
      issue_en = 1'b1; issue_rd = 5'd4;
      tick();
      idle();
      #1;
      chk("err_set_b", err_b, 1'b1);
      chk("err_set_n", err_n, 1'b1);
      tick();
      #1;
      chk("err_sticky", err_b, 1'b1);

      // 6: pending state and data are dropped by reset
      wen = 1'b1; waddr = 5'd2; wdata = 32'h22;
      tick();
      waddr = 5'd6; wdata = 32'h66;
      tick();
      idle();
      issue_en = 1'b1; issue_rd = 5'd2;
      tick();
      issue_rd = 5'd6;
      tick();
      idle();
      raddr = {5'd6, 5'd2};
      #1;
      chk("pre_rst_busy",  busy_vec_b, 32'h0000_0054);
      chk("pre_rst_rdata", rdata_b,    {32'h66, 32'h22});
      rst_n = 1'b0; wen = 1'b1; waddr = 5'd5; wdata = 32'h55; issue_en = 1'b1; issue_rd = 5'd5;
      tick();
      rst_n = 1'b1;
      idle();
      #1;
      chk("post_rst_busy",   busy_vec_b, 32'h0);
      chk("post_rst_err",    err_b,      1'b0);
      chk("post_rst_rdata",  rdata_b,    64'h0);
      chk("post_rst_rsbusy", rs_busy_b,  2'b00);
      raddr = {5'd5, 5'd3};
      #1;
      chk("post_rst_x3x5",   rdata_n,    64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_regfile_sb
